// File: rtl/cic_decimator_if.sv
// Sample-stream interface of the CIC decimator.
//
// Handshake: there is no backpressure. The source presents a new x_in on
// every clock; out_tick acts as a single-cycle valid for x_out, and the sink
// must take x_out in the cycle out_tick is high. x_out holds its value
// between ticks. rate_sel is a static control that the decimator resamples
// only at its own decimation boundary. dbg_count and dbg_sel mirror the
// decimation counter and the active rate select for observation only.
interface cic_decimator_if #(
    parameter int IW = 16,
    parameter int SW = 3,
    parameter int CW = 11
);
    logic signed [IW-1:0] x_in;
    logic [SW-1:0]        rate_sel;
    logic signed [IW-1:0] x_out;
    logic                 out_tick;
    logic [CW-1:0]        dbg_count;
    logic [SW-1:0]        dbg_sel;

    modport master (
        output x_in,
        output rate_sel,
        input  x_out,
        input  out_tick,
        input  dbg_count,
        input  dbg_sel
    );

    modport slave (
        input  x_in,
        input  rate_sel,
        output x_out,
        output out_tick,
        output dbg_count,
        output dbg_sel
    );
endinterface

// File: rtl/cic_decimator.sv
// N-stage CIC (Hogenauer) decimator, differential delay 1, power-of-two
// decimation ratio R = 2^(RLOG_MIN + rate_sel). The integrators run at the
// input rate in W-bit modular arithmetic; the comb chain is evaluated
// combinationally in the strobe cycle and the result is registered. The
// output slice divides by the DC gain R^N = 2^(N*log2 R), so a constant
// input reappears unchanged at x_out once the filter has settled.
module cic_decimator #(
    parameter int N        = 4,
    parameter int RLOG_MIN = 4,
    parameter int RLOG_MAX = 11,
    parameter int IW       = 16
) (
    input  logic            CLK,
    input  logic            RSTb,
    cic_decimator_if.slave  bus
);

    // Number of selectable ratios and width of the select
    localparam int NSEL = RLOG_MAX - RLOG_MIN + 1;
    localparam int SW   = (NSEL > 1) ? $clog2(NSEL) : 1;
    // Internal width: enough headroom for the worst-case gain R^N
    localparam int W    = IW + N * RLOG_MAX;
    localparam int CW   = RLOG_MAX;

    // Rate selection
    logic          load_sel;
    logic [SW-1:0] sel_active;

    // Decimation counter
    logic [CW-1:0] count;
    logic [CW-1:0] r_last;
    logic          strobe;

    // Integrator chain
    logic [W-1:0]  integ [N];

    // Comb chain: comb_in[k] is the input of comb k, comb_d[k] its delay
    logic [W-1:0]  comb_in [N];
    logic [W-1:0]  comb_d  [N];
    logic [W-1:0]  comb_out;

    // Registered comb result and the select it must be sliced with
    logic [W-1:0]  cn_q;
    logic [SW-1:0] sel_q;
    logic          strobe_d;

    // Candidate output slices, one per decimation ratio
    logic [IW-1:0] taps [2**SW];

    // ------------------------------------------------------------------
    // Rate selection
    // ------------------------------------------------------------------

    // Load flag: high throughout reset and for the first clock after it
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            load_sel <= 1'b1;
        end else begin
            load_sel <= 1'b0;
        end
    end

    // Active rate: tracks rate_sel while in reset, then only on a strobe,
    // so a new ratio always starts from a counter wrap
    always_ff @(posedge CLK) begin
        if (load_sel || strobe) begin
            sel_active <= bus.rate_sel;
        end
    end

    // ------------------------------------------------------------------
    // Decimation counter
    // ------------------------------------------------------------------

    // Terminal count R-1: the low RLOG_MIN+sel bits set
    always_comb begin
        r_last = '0;
        for (int i = 0; i < CW; i++) begin
            r_last[i] = (i < (RLOG_MIN + int'(sel_active)));
        end
    end

    assign strobe = (count == r_last);

    // Count 0..R-1 and wrap on the strobe
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            count <= '0;
        end else if (strobe) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Integrators
    // ------------------------------------------------------------------

    // Cascade of accumulators at full rate; wrap-around is intentional,
    // the combs cancel it exactly
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            for (int k = 0; k < N; k++) begin
                integ[k] <= '0;
            end
        end else begin
            integ[0] <= integ[0] + {{(W-IW){bus.x_in[IW-1]}}, bus.x_in};
            for (int k = 1; k < N; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Combs
    // ------------------------------------------------------------------

    // Comb chain evaluated combinationally from the last integrator
    always_comb begin
        logic [W-1:0] acc;
        acc = integ[N-1];
        for (int k = 0; k < N; k++) begin
            comb_in[k] = acc;
            acc        = acc - comb_d[k];
        end
        comb_out = acc;
    end

    // On the strobe, advance the comb delays and capture the result
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            for (int k = 0; k < N; k++) begin
                comb_d[k] <= '0;
            end
            cn_q     <= '0;
            sel_q    <= '0;
            strobe_d <= 1'b0;
        end else begin
            strobe_d <= strobe;
            if (strobe) begin
                for (int k = 0; k < N; k++) begin
                    comb_d[k] <= comb_in[k];
                end
                cn_q  <= comb_out;
                sel_q <= sel_active;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output select
    // ------------------------------------------------------------------

    // Slice at bit N*log2(R): truncating division by the DC gain
    for (genvar g = 0; g < 2**SW; g++) begin : g_tap
        if (g < NSEL) begin : g_live
            assign taps[g] = cn_q[N*(RLOG_MIN+g) +: IW];
        end else begin : g_pad
            assign taps[g] = '0;
        end
    end

    // Register the selected slice and raise out_tick for that one cycle
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            bus.x_out    <= '0;
            bus.out_tick <= 1'b0;
        end else begin
            bus.out_tick <= strobe_d;
            if (strobe_d) begin
                bus.x_out <= taps[sel_q];
            end
        end
    end

    assign bus.dbg_count = count;
    assign bus.dbg_sel   = sel_active;

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator. The reference computes each expected output as
// an N-fold moving sum of length R over the input history (the CIC impulse
// response), arithmetic-shifted by log2(R^N) and truncated to 16 bits.
module tb_cic_decimator;

    localparam int N        = 4;
    localparam int RLOG_MIN = 4;
    localparam int RLOG_MAX = 11;
    localparam int IW       = 16;
    localparam int SW       = 3;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk  = 1'b0;
    logic rstb = 1'b1;
    always #5 clk = ~clk;

    logic signed [15:0] x_drv   = 16'h1234;
    logic [2:0]         sel_drv = 3'd0;

    cic_decimator_if #(.IW(IW), .SW(SW), .CW(RLOG_MAX)) bus ();

    assign bus.x_in     = x_drv;
    assign bus.rate_sel = sel_drv;

    cic_decimator #(
        .N(N), .RLOG_MIN(RLOG_MIN), .RLOG_MAX(RLOG_MAX), .IW(IW)
    ) dut (
        .CLK  (clk),
        .RSTb (rstb),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: edge counting from the decimation rules, input
    // history, and the direct FIR form of the CIC response
    // ------------------------------------------------------------------
    int unsigned  cyc = 0;
    int           m_cnt = 0;
    int           m_sel = 0;
    int           run_at_rate = 0;
    bit           from_reset = 1'b1;
    longint       hist[$];
    logic [48:0]  exp_q[$];     // {care, due cycle, value}

    // y(t) = sum over lags of (box_R * ... * box_R)[lag] * x(t - N - lag)
    function automatic longint box_filter(input int t, input int r);
        longint cur[];
        longint nxt[];
        longint acc;
        int     m, lo, len, nlen, e;
        m   = t - N;
        len = N * (r - 1) + 1;
        lo  = m - (len - 1);
        cur = new[len];
        for (int p = 0; p < len; p++) begin
            e = lo + p;
            cur[p] = (e >= 1 && e <= hist.size()) ? hist[e-1] : 64'sd0;
        end
        for (int st = 0; st < N; st++) begin
            nlen = len - (r - 1);
            nxt  = new[nlen];
            acc  = 0;
            for (int j = 0; j < r; j++) acc += cur[j];
            nxt[0] = acc;
            for (int p = 1; p < nlen; p++) begin
                acc    = acc + cur[p+r-1] - cur[p-1];
                nxt[p] = acc;
            end
            cur = nxt;
            len = nlen;
        end
        return cur[0];
    endfunction

    longint      y_ref, y_shift;
    logic [15:0] exp_val;
    bit          care;

    always @(posedge clk) begin
        cyc++;
        if (!rstb) begin
            hist.delete();
            exp_q.delete();
            m_cnt       = 0;
            m_sel       = int'(sel_drv);
            from_reset  = 1'b1;
            run_at_rate = 0;
        end else begin
            hist.push_back(longint'(x_drv));
            if (m_cnt == (1 << (RLOG_MIN + m_sel)) - 1) begin
                run_at_rate++;
                y_ref   = box_filter(hist.size(), 1 << (RLOG_MIN + m_sel));
                y_shift = y_ref >>> (N * (RLOG_MIN + m_sel));
                exp_val = y_shift[15:0];
                care    = from_reset || (run_at_rate >= N);
                exp_q.push_back({care, 32'(cyc + 1), exp_val});
                m_cnt = 0;
                if (int'(sel_drv) != m_sel) begin
                    m_sel       = int'(sel_drv);
                    from_reset  = 1'b0;
                    run_at_rate = 0;
                end
            end else begin
                m_cnt++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    logic [15:0] held    = 16'h0;
    bit          held_ok = 1'b0;
    logic [48:0] ent;

    always @(negedge clk) begin
        #1;
        if (!rstb) begin
            check("reset_x_out", {16'd0, bus.x_out}, 32'd0);
            check("reset_tick", {31'd0, bus.out_tick}, 32'd0);
            held    = 16'h0;
            held_ok = 1'b1;
        end else if (bus.out_tick) begin
            if (exp_q.size() == 0) begin
                check("spurious_tick", 32'd1, 32'd0);
            end else begin
                ent = exp_q.pop_front();
                check("tick_cycle", cyc, ent[47:16]);
                if (ent[48]) begin
                    check("x_out", {16'd0, bus.x_out}, {16'd0, ent[15:0]});
                    held    = ent[15:0];
                    held_ok = 1'b1;
                end else begin
                    held_ok = 1'b0;
                end
            end
        end else if (held_ok) begin
            check("x_out_hold", {16'd0, bus.x_out}, {16'd0, held});
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive_const(input int n, input logic [15:0] x, input logic [2:0] s);
        repeat (n) begin
            @(negedge clk);
            x_drv   = x;
            sel_drv = s;
        end
    endtask

    task automatic drive_rand(input int n, input logic [2:0] s);
        repeat (n) begin
            @(negedge clk);
            x_drv   = 16'($urandom_range(0, 65535));
            sel_drv = s;
        end
    endtask

    task automatic wait_first_tick(input int expect_n);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < expect_n + 32) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.out_tick) seen = 1'b1;
        end
        check("first_tick_clock", n, expect_n);
    endtask

    task automatic check_now(input string name, input logic [15:0] req);
        #2;
        check(name, {16'd0, bus.x_out}, {16'd0, req});
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int stale;
    int guard;

    initial begin
        // Reset with a nonzero input present
        #1;
        rstb = 1'b0;
        repeat (6) @(negedge clk);
        rstb = 1'b1;
        wait_first_tick(17);

        // DC gain at R=16
        drive_const(200, 16'h1000, 3'd0);
        check_now("dc_0x1000", 16'h1000);

        // Random levels, random noise, random ratio changes
        for (int seg = 0; seg < 8; seg++) begin
            if (seg % 2 == 1) begin
                drive_rand($urandom_range(100, 400), 3'($urandom_range(0, 2)));
            end else begin
                drive_const($urandom_range(100, 400), 16'($urandom), 3'($urandom_range(0, 2)));
            end
        end

        // Rate change R=16 -> R=128 on a DC input
        drive_const(300, 16'h0400, 3'd0);
        drive_const(1400, 16'h0400, 3'd3);
        check_now("rate_change_dc", 16'h0400);

        // Mid-run reset when the counter reads 7
        drive_const(40, 16'h0400, 3'd0);
        guard = 0;
        while (m_cnt != 7 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("count_at_reset", {21'd0, bus.dbg_count}, 32'd7);
        rstb = 1'b0;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        wait_first_tick(17);
        drive_const(120, 16'h0400, 3'd0);

        // Full scale at R=2048
        @(negedge clk);
        rstb    = 1'b0;
        x_drv   = 16'h8000;
        sel_drv = 3'd7;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        wait_first_tick(2049);
        drive_const(6 * 2048, 16'h8000, 3'd7);
        check_now("full_scale_neg", 16'h8000);
        drive_const(7 * 2048, 16'h7FFF, 3'd7);
        check_now("full_scale_pos", 16'h7FFF);

        // Back to a fast ratio with random full-scale input
        drive_rand(600, 3'd1);
        drive_const(80, 16'h0000, 3'd1);

        // Every due tick must have been seen
        #2;
        stale = 0;
        foreach (exp_q[i]) begin
            if (exp_q[i][47:16] <= cyc) stale++;
        end
        check("pending_ticks", stale, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
